// File: rtl/riscv_hart_core_if.sv
// ============================================================================
// Module : riscv_hart_core_if
// Brief  : Instruction-fetch and data-memory bus of the RV32I hart.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface riscv_hart_core_if #(
    parameter int XLEN = 32,
    parameter int ALEN = 32
);
    logic [31:0]     instruction;
    logic [ALEN-1:0] pc;
    logic [XLEN-1:0] mem_read;
    logic [ALEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_write;

    modport master (
        input  instruction,
        input  mem_read,
        output pc,
        output mem_addr,
        output mem_data,
        output mem_write
    );

    modport slave (
        output instruction,
        output mem_read,
        input  pc,
        input  mem_addr,
        input  mem_data,
        input  mem_write
    );
endinterface

`default_nettype wire

// File: rtl/riscv_hart_core.sv
// ============================================================================
// Module : riscv_hart_core
// Brief  : Multi-cycle RV32I hart (FETCH / EXEC / LOAD_WB), 2 or 3 cycles/instr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module riscv_hart_core #(
    parameter int XLEN = 32,
    parameter int ALEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_hart_core_if.master     bus
);
    typedef logic [31:0] instruction_t;
    typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, LOAD_WB = 2'd2} state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    state_t          state_q, state_d;
    logic [ALEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];

    instruction_t    instr;
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rs1_val, rs2_val, alu_b, alu_res, ea;
    logic [4:0]      shamt;
    logic            is_op, is_lw, is_sw, br_taken;
    logic [ALEN-1:0] pc_plus4, ea_a, jalr_target;
    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;
    logic            mem_write_c;
    logic [ALEN-1:0] mem_addr_c;
    logic [XLEN-1:0] mem_data_c;

    assign instr  = bus.instruction;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // x0 is never written, so its entry stays at the reset value of zero
    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];

    assign is_op  = (opcode == OPC_OP);
    assign is_lw  = (opcode == OPC_LOAD)  && (f3 == 3'b010);
    assign is_sw  = (opcode == OPC_STORE) && (f3 == 3'b010);
    assign alu_b  = is_op ? rs2_val : imm_i;
    assign shamt  = alu_b[4:0];

    assign ea          = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign ea_a        = ALEN'(ea);
    assign pc_plus4    = pc_q + ALEN'(4);
    assign jalr_target = ALEN'(rs1_val + imm_i) & ~ALEN'(1);

    always_comb begin
        alu_res = '0;
        case (f3)
            3'b000:  alu_res = (is_op && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << shamt;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, rs1_val < alu_b};
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = instr[30] ? XLEN'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        regs_d      = regs_q;
        rf_we       = 1'b0;
        rf_wdata    = '0;
        mem_write_c = 1'b0;
        mem_addr_c  = '0;
        mem_data_c  = '0;
        case (state_q)
            FETCH: state_d = EXEC;
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_plus4;
                case (opcode)
                    OPC_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
                    OPC_AUIPC: begin rf_we = 1'b1; rf_wdata = XLEN'(pc_q) + imm_u; end
                    OPC_JAL: begin
                        rf_we    = 1'b1;
                        rf_wdata = XLEN'(pc_plus4);
                        pc_d     = pc_q + ALEN'(imm_j);
                    end
                    OPC_JALR: begin
                        rf_we    = 1'b1;
                        rf_wdata = XLEN'(pc_plus4);
                        pc_d     = jalr_target;
                    end
                    OPC_BRANCH: if (br_taken) pc_d = pc_q + ALEN'(imm_b);
                    OPC_LOAD: if (is_lw) begin
                        state_d    = LOAD_WB;
                        pc_d       = pc_q;
                        mem_addr_c = ea_a;
                    end
                    OPC_STORE: if (is_sw) begin
                        mem_write_c = 1'b1;
                        mem_addr_c  = ea_a;
                        mem_data_c  = rs2_val;
                    end
                    OPC_OPIMM, OPC_OP: begin rf_we = 1'b1; rf_wdata = alu_res; end
                    default: ;
                endcase
            end
            LOAD_WB: begin
                // instruction is still the LW: pc has not moved since FETCH
                mem_addr_c = ea_a;
                rf_we      = 1'b1;
                rf_wdata   = bus.mem_read;
                pc_d       = pc_plus4;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (rf_we && (rd != 5'd0)) regs_d[rd] = rf_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            regs_q  <= regs_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.mem_write = mem_write_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_data  = mem_data_c;
endmodule

`default_nettype wire

// File: tb/tb_riscv_hart_core.sv
// ============================================================================
// Module : tb_riscv_hart_core
// Brief  : Self-checking bench: ROM/RAM model plus a store scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_riscv_hart_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] rom  [64];
    logic [31:0] dmem [64];
    logic [63:0] sb_q [$];

    riscv_hart_core_if #(.XLEN(32), .ALEN(32)) bus ();
    riscv_hart_core #(.XLEN(32), .ALEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Environment: registered ROM and one-cycle-latency RAM
    always @(posedge clk) begin
        bus.instruction <= rom[bus.pc[7:2]];
        if (bus.mem_write) dmem[bus.mem_addr[7:2]] <= bus.mem_data;
        else               bus.mem_read <= dmem[bus.mem_addr[7:2]];
    end

    // Store scoreboard: every store must match the next expected {addr,data}
    always @(negedge clk) begin
        if (bus.mem_write) begin
            checks++;
            if (rst) begin
                errors++;
                $display("FAIL store_during_reset addr=%h data=%h required no store", bus.mem_addr, bus.mem_data);
            end else if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_store addr=%h data=%h required none", bus.mem_addr, bus.mem_data);
            end else begin
                logic [63:0] exp;
                exp = sb_q.pop_front();
                if ({bus.mem_addr, bus.mem_data} !== exp) begin
                    errors++;
                    $display("FAIL store got addr=%h data=%h required addr=%h data=%h",
                             bus.mem_addr, bus.mem_data, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic clear_env();
        for (int i = 0; i < 64; i++) begin rom[i] = 32'h0; dmem[i] = 32'h0; end
        sb_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_sb_empty(string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending_stores=%0d required 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        clear_env();
        rom[0] = enc_s(12'h03C, 5'd0, 5'd0);
        apply_reset();
        step(1);
        // DUT is in EXEC of a SW; asynchronous reset must kill the strobe at once
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.pc, bus.mem_write, bus.mem_addr, bus.mem_data} !== 97'h0) begin
            errors++;
            $display("FAIL reset_outputs pc=%h we=%b addr=%h data=%h required all 0",
                     bus.pc, bus.mem_write, bus.mem_addr, bus.mem_data);
        end
        step(1);
        checks++;
        if (bus.pc !== 32'h0 || bus.mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold pc=%h we=%b required 0/0", bus.pc, bus.mem_write);
        end
        rom[0] = 32'h0;
    endtask

    task automatic test_alu();
        clear_env();
        rom[0] = enc_i(12'd5,   5'd0, 3'b000, 5'd1, 7'h13);
        rom[1] = enc_i(12'hFF9, 5'd1, 3'b000, 5'd2, 7'h13);
        rom[2] = enc_s(12'd0, 5'd1, 5'd0);
        rom[3] = enc_s(12'd4, 5'd2, 5'd0);
        sb_q.push_back({32'd0, 32'd5});
        sb_q.push_back({32'd4, 32'hFFFF_FFFE});
        apply_reset();
        step(7);
        checks++;
        if (bus.pc !== 32'd12) begin errors++; $display("FAIL alu_pc_7 pc=%0d required 12", bus.pc); end
        step(1);
        checks++;
        if (bus.pc !== 32'd16) begin errors++; $display("FAIL alu_pc_8 pc=%0d required 16", bus.pc); end
        checks++;
        if (dmem[0] !== 32'd5 || dmem[1] !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL alu_mem d0=%h d1=%h required 00000005 fffffffe", dmem[0], dmem[1]);
        end
        check_sb_empty("alu_sb");
    endtask

    task automatic test_load_store();
        clear_env();
        dmem[3] = 32'h0000_DEAD;
        rom[0] = enc_i(12'h123, 5'd0, 3'b000, 5'd1, 7'h13);
        rom[1] = enc_s(12'd12, 5'd1, 5'd0);
        rom[2] = enc_i(12'd12,  5'd0, 3'b010, 5'd2, 7'h03);
        rom[3] = enc_r(7'h00, 5'd1, 5'd2, 3'b000, 5'd3);
        rom[4] = enc_s(12'd16, 5'd3, 5'd0);
        sb_q.push_back({32'd12, 32'h123});
        sb_q.push_back({32'd16, 32'h246});
        apply_reset();
        step(6);
        checks++;
        if (bus.pc !== 32'd8 || bus.mem_addr !== 32'd12 || bus.mem_write !== 1'b0) begin
            errors++;
            $display("FAIL lw_wb pc=%0d addr=%0d we=%b required 8/12/0", bus.pc, bus.mem_addr, bus.mem_write);
        end
        step(1);
        checks++;
        if (bus.pc !== 32'd12) begin errors++; $display("FAIL lw_3cyc pc=%0d required 12", bus.pc); end
        step(4);
        checks++;
        if (bus.pc !== 32'd20 || dmem[4] !== 32'h246) begin
            errors++;
            $display("FAIL ls_end pc=%0d d4=%h required 20/00000246", bus.pc, dmem[4]);
        end
        check_sb_empty("ls_sb");
    endtask

    task automatic test_branch_jump();
        int  n = 0;
        bit  hit_skip = 0;
        clear_env();
        dmem[9] = 32'h0000_AAAA;
        rom[0] = enc_i(12'd3,   5'd0, 3'b000, 5'd1, 7'h13);
        rom[1] = enc_i(12'd0,   5'd0, 3'b000, 5'd2, 7'h13);
        rom[2] = enc_i(12'd1,   5'd2, 3'b000, 5'd2, 7'h13);
        rom[3] = enc_i(12'hFFF, 5'd1, 3'b000, 5'd1, 7'h13);
        rom[4] = enc_b(13'h1FF8, 5'd0, 5'd1, 3'b001);
        rom[5] = enc_s(12'h020, 5'd2, 5'd0);
        rom[6] = enc_j(21'd8, 5'd5);
        rom[7] = enc_s(12'h024, 5'd1, 5'd0);
        rom[8] = enc_s(12'h028, 5'd5, 5'd0);
        sb_q.push_back({32'h20, 32'd3});
        sb_q.push_back({32'h28, 32'd28});
        apply_reset();
        while (bus.pc !== 32'd36 && n < 100) begin
            step(1);
            n++;
            if (bus.pc === 32'd28) hit_skip = 1;
        end
        checks++;
        if (bus.pc !== 32'd36) begin errors++; $display("FAIL br_timeout pc=%0d required 36", bus.pc); end
        checks++;
        if (hit_skip) begin errors++; $display("FAIL jal_skip pc visited 28 required never"); end
        checks++;
        if (dmem[8] !== 32'd3 || dmem[9] !== 32'h0000_AAAA || dmem[10] !== 32'd28) begin
            errors++;
            $display("FAIL br_mem d8=%h d9=%h d10=%h required 3/aaaa/1c", dmem[8], dmem[9], dmem[10]);
        end
        check_sb_empty("br_sb");
    endtask

    task automatic test_shift_compare();
        int n = 0;
        clear_env();
        dmem[13] = 32'h0000_FFFF;
        rom[0] = {20'h80000, 5'd1, 7'h37};
        rom[1] = enc_i(12'h404, 5'd1, 3'b101, 5'd2, 7'h13);
        rom[2] = enc_s(12'h030, 5'd2, 5'd0);
        rom[3] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd3, 7'h13);
        rom[4] = enc_i(12'd1,   5'd0, 3'b000, 5'd4, 7'h13);
        rom[5] = enc_r(7'h00, 5'd4, 5'd3, 3'b011, 5'd5);
        rom[6] = enc_r(7'h00, 5'd4, 5'd3, 3'b010, 5'd6);
        rom[7] = enc_s(12'h034, 5'd5, 5'd0);
        rom[8] = enc_s(12'h038, 5'd6, 5'd0);
        sb_q.push_back({32'h30, 32'hF800_0000});
        sb_q.push_back({32'h34, 32'd0});
        sb_q.push_back({32'h38, 32'd1});
        apply_reset();
        while (bus.pc !== 32'd36 && n < 100) begin step(1); n++; end
        checks++;
        if (bus.pc !== 32'd36) begin errors++; $display("FAIL sh_timeout pc=%0d required 36", bus.pc); end
        checks++;
        if (dmem[12] !== 32'hF800_0000 || dmem[13] !== 32'd0 || dmem[14] !== 32'd1) begin
            errors++;
            $display("FAIL sh_mem d12=%h d13=%h d14=%h required f8000000/0/1", dmem[12], dmem[13], dmem[14]);
        end
        check_sb_empty("sh_sb");
    endtask

    task automatic test_x0_nop();
        clear_env();
        dmem[2] = 32'h0000_5555;
        rom[0] = enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'h13);
        rom[1] = enc_s(12'd8, 5'd0, 5'd0);
        rom[2] = 32'h0000_0000;
        rom[3] = enc_i(12'd7, 5'd0, 3'b000, 5'd7, 7'h13);
        rom[4] = enc_s(12'h03C, 5'd7, 5'd0);
        sb_q.push_back({32'd8, 32'd0});
        sb_q.push_back({32'h3C, 32'd7});
        apply_reset();
        step(6);
        checks++;
        if (bus.pc !== 32'd12) begin errors++; $display("FAIL nop_pc pc=%0d required 12", bus.pc); end
        step(4);
        checks++;
        if (bus.pc !== 32'd20 || dmem[2] !== 32'd0 || dmem[15] !== 32'd7) begin
            errors++;
            $display("FAIL x0_end pc=%0d d2=%h d15=%h required 20/0/7", bus.pc, dmem[2], dmem[15]);
        end
        check_sb_empty("x0_sb");
    endtask

    task automatic test_reset_mid_load();
        clear_env();
        dmem[17] = 32'h0000_0077;
        dmem[18] = 32'h0000_0099;
        rom[0] = enc_i(12'h044, 5'd0, 3'b010, 5'd1, 7'h03);
        apply_reset();
        step(2);
        checks++;
        if (bus.pc !== 32'd0 || bus.mem_addr !== 32'h44) begin
            errors++;
            $display("FAIL mid_load_state pc=%0d addr=%h required 0/44", bus.pc, bus.mem_addr);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.pc !== 32'd0 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL mid_load_reset pc=%0d we=%b addr=%h required 0/0/0", bus.pc, bus.mem_write, bus.mem_addr);
        end
        // New word at 0 stores x1: it must still be zero because the load never retired
        rom[0] = enc_s(12'h048, 5'd1, 5'd0);
        sb_q.push_back({32'h48, 32'd0});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(2);
        checks++;
        if (bus.pc !== 32'd4 || dmem[18] !== 32'd0) begin
            errors++;
            $display("FAIL restart pc=%0d d18=%h required 4/0", bus.pc, dmem[18]);
        end
        check_sb_empty("restart_sb");
    endtask

    initial begin
        bus.instruction = 32'h0;
        bus.mem_read    = 32'h0;
        clear_env();
        test_reset();
        test_alu();
        test_load_store();
        test_branch_jump();
        test_shift_compare();
        test_x0_nop();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
